// File: rtl/emu_time_monitor_pkg.sv
// rtl/emu_time_monitor_pkg.sv - DCO code width and monitor FSM state encoding.
package emu_time_monitor_pkg;
  localparam int DCO_CODE_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } MON_STATE;
endpackage

// File: rtl/time_package.sv
// rtl/time_package.sv - emulated time format shared by the emulator and its observers.
package time_package;
  localparam int TIME_WIDTH = 32;
  typedef logic [TIME_WIDTH-1:0] TIME_FORMAT;
endpackage

// File: rtl/mon_cap_fifo.sv
// rtl/mon_cap_fifo.sv - synchronous capture FIFO with registered read, full/empty and sticky overflow.
module mon_cap_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a write while full still lands if a read accompanies it.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = do_rd;
    ovf_d      = ovf_q | (wr_en && !do_wr);
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
endmodule

// File: rtl/emu_time_monitor.sv
// rtl/emu_time_monitor.sv - emulated-time accumulator with sticky trigger flag and decimated DCO capture.
// Capture path is built only when TIME_MON_CAPTURE_EN is defined.
module emu_time_monitor
  import emu_time_monitor_pkg::*;
#(
  parameter int TIME_WIDTH  = time_package::TIME_WIDTH,
  parameter int DCO_WIDTH   = DCO_CODE_WIDTH,
  parameter int DECIM_WIDTH = 8,
  parameter int CAP_DEPTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   emu_step,
  input  logic [TIME_WIDTH-1:0]  dt,
  input  logic [TIME_WIDTH-1:0]  time_trig,
  input  logic                   dco_valid,
  input  logic [DCO_WIDTH-1:0]   dco_code,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [TIME_WIDTH-1:0]  emu_time,
  output logic                   time_flag,
  input  logic                   rd_en,
  output logic [DCO_WIDTH-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   cap_empty,
  output logic                   cap_full,
  output logic                   cap_ovf
);
  MON_STATE              state_q, state_d;
  logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;
  logic                  time_flag_q, time_flag_d;
  logic [TIME_WIDTH:0]   sum;
  logic                  trig_hit;

  assign sum      = {1'b0, emu_time_q} + {1'b0, dt};
  assign trig_hit = (emu_time_q >= time_trig);

  // Once the trigger is reached the accumulator stops, so emu_time reports the crossing value.
  always_comb begin
    state_d    = state_q;
    emu_time_d = emu_time_q;
    case (state_q)
      IDLE: begin
        emu_time_d = '0;
        if (arm) state_d = RUN;
      end
      RUN: begin
        if (!arm) begin
          state_d    = IDLE;
          emu_time_d = '0;
        end else if (trig_hit) begin
          state_d = DONE;
        end else if (emu_step) begin
          emu_time_d = sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
        end
      end
      DONE: begin
        if (!arm) begin
          state_d    = IDLE;
          emu_time_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        emu_time_d = '0;
      end
    endcase
    time_flag_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      emu_time_q  <= '0;
      time_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      emu_time_q  <= emu_time_d;
      time_flag_q <= time_flag_d;
    end
  end

  assign emu_time  = emu_time_q;
  assign time_flag = time_flag_q;

`ifdef TIME_MON_CAPTURE_EN
  logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic                   cap_wr;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    cap_wr    = 1'b0;
    if (state_q == IDLE) begin
      dec_cnt_d = '0;
    end else if ((state_q == RUN) && dco_valid) begin
      if (dec_cnt_q == decim) begin
        cap_wr    = 1'b1;
        dec_cnt_d = '0;
      end else begin
        dec_cnt_d = dec_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_cnt_q <= '0;
    else     dec_cnt_q <= dec_cnt_d;
  end

  mon_cap_fifo #(
    .DEPTH (CAP_DEPTH),
    .WIDTH (DCO_WIDTH)
  ) u_cap_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cap_wr),
    .wr_data  (dco_code),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (cap_empty),
    .full     (cap_full),
    .ovf      (cap_ovf)
  );
`else
  logic unused_cap;
  assign unused_cap = ^{dco_valid, dco_code, decim, rd_en, CAP_DEPTH[0]};
  assign rd_data    = '0;
  assign rd_valid   = 1'b0;
  assign cap_empty  = 1'b1;
  assign cap_full   = 1'b0;
  assign cap_ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_emu_time_monitor.sv
// tb/tb_emu_time_monitor.sv - directed self-checking bench for emu_time_monitor.
module tb_emu_time_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        emu_step;
  logic [31:0] dt;
  logic [31:0] time_trig;
  logic        dco_valid;
  logic [13:0] dco_code;
  logic [7:0]  decim;
  logic [31:0] emu_time;
  logic        time_flag;
  logic        rd_en;
  logic [13:0] rd_data;
  logic        rd_valid;
  logic        cap_empty;
  logic        cap_full;
  logic        cap_ovf;

  int err_cnt = 0;
  int chk_cnt = 0;

  emu_time_monitor #(
    .TIME_WIDTH  (32),
    .DCO_WIDTH   (14),
    .DECIM_WIDTH (8),
    .CAP_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .emu_step  (emu_step),
    .dt        (dt),
    .time_trig (time_trig),
    .dco_valid (dco_valid),
    .dco_code  (dco_code),
    .decim     (decim),
    .emu_time  (emu_time),
    .time_flag (time_flag),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cap_empty (cap_empty),
    .cap_full  (cap_full),
    .cap_ovf   (cap_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disarm();
    arm      = 1'b0;
    emu_step = 1'b0;
    tick();
  endtask

  // trig=100, dt=30, step every cycle: 30,60,90,120 then flag, emu_time held at 120
  task automatic run_accum(input string pfx);
    time_trig = 32'd100;
    dt        = 32'd30;
    emu_step  = 1'b1;
    arm       = 1'b1;
    tick();
    check({pfx, "_run_time"}, emu_time, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check({pfx, "_acc_time"}, emu_time, 32'd30 * k);
      check({pfx, "_acc_flag"}, {31'd0, time_flag}, 32'd0);
    end
    tick();
    check({pfx, "_trig_flag"}, {31'd0, time_flag}, 32'd1);
    check({pfx, "_trig_time"}, emu_time, 32'd120);
    tick();
    check({pfx, "_hold_time"}, emu_time, 32'd120);
    check({pfx, "_hold_flag"}, {31'd0, time_flag}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; emu_step = 1'b0; dt = '0; time_trig = '0;
    dco_valid = 1'b0; dco_code = '0; decim = '0; rd_en = 1'b0;
    tick();
    tick();
    check("rst_time", emu_time, 32'd0);
    check("rst_flag", {31'd0, time_flag}, 32'd0);
    check("rst_rd_data", {18'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_empty", {31'd0, cap_empty}, 32'd1);
    check("rst_full", {31'd0, cap_full}, 32'd0);
    check("rst_ovf", {31'd0, cap_ovf}, 32'd0);
    rst = 1'b0;
    tick();

    run_accum("accum");
    disarm();
    check("disarm_flag", {31'd0, time_flag}, 32'd0);
    check("disarm_time", emu_time, 32'd0);
    run_accum("rearm");
    disarm();

    time_trig = 32'd0;
    arm = 1'b1;
    tick();
    check("zero_run_flag", {31'd0, time_flag}, 32'd0);
    tick();
    check("zero_flag", {31'd0, time_flag}, 32'd1);
    check("zero_time", emu_time, 32'd0);
    disarm();

    dt = 32'hFFFF_FFFF; time_trig = 32'hFFFF_FFFF; emu_step = 1'b1; arm = 1'b1;
    tick();
    tick();
    check("sat1_time", emu_time, 32'hFFFF_FFFF);
    check("sat1_flag", {31'd0, time_flag}, 32'd0);
    tick();
    check("sat1_trig", {31'd0, time_flag}, 32'd1);
    check("sat1_hold", emu_time, 32'hFFFF_FFFF);
    disarm();

    // second step carries out of 32 bits and must clamp
    dt = 32'hC000_0000; emu_step = 1'b1; arm = 1'b1;
    tick();
    tick();
    check("sat2_step1", emu_time, 32'hC000_0000);
    tick();
    check("sat2_clamp", emu_time, 32'hFFFF_FFFF);
    check("sat2_noflag", {31'd0, time_flag}, 32'd0);
    tick();
    check("sat2_flag", {31'd0, time_flag}, 32'd1);
    disarm();

    // capture: decim=3 over codes 0..19 into a 4-deep buffer
    time_trig = 32'hFFFF_FFFF; decim = 8'd3; arm = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      dco_valid = 1'b1;
      dco_code  = 14'(i);
      tick();
`ifdef TIME_MON_CAPTURE_EN
      if (i == 18) begin
        check("cap_full_pre", {31'd0, cap_full}, 32'd1);
        check("cap_ovf_pre", {31'd0, cap_ovf}, 32'd0);
      end
`endif
    end
    dco_valid = 1'b0;
    tick();
`ifdef TIME_MON_CAPTURE_EN
    check("cap_full", {31'd0, cap_full}, 32'd1);
    check("cap_ovf", {31'd0, cap_ovf}, 32'd1);
    check("cap_not_empty", {31'd0, cap_empty}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pop_valid", {31'd0, rd_valid}, 32'd1);
      check("pop_data", {18'd0, rd_data}, 32'd3 + 32'd4 * k);
      tick();
      check("pop_valid_off", {31'd0, rd_valid}, 32'd0);
    end
    check("pop_empty", {31'd0, cap_empty}, 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_on_empty", {31'd0, rd_valid}, 32'd0);
    check("ovf_sticky", {31'd0, cap_ovf}, 32'd1);
`else
    check("nocap_empty", {31'd0, cap_empty}, 32'd1);
    check("nocap_full", {31'd0, cap_full}, 32'd0);
    check("nocap_ovf", {31'd0, cap_ovf}, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("nocap_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("nocap_rd_data", {18'd0, rd_data}, 32'd0);
`endif
    disarm();

    // async reset mid-RUN, with a read strobe in flight when capture is built
    dt = 32'd5; time_trig = 32'hFFFF_FFFF; decim = 8'd0; arm = 1'b1; emu_step = 1'b1;
    dco_valid = 1'b1; dco_code = 14'd42;
    tick();
    tick();
    dco_valid = 1'b0;
    tick();
    check("pre_rst_time", emu_time, 32'd10);
`ifdef TIME_MON_CAPTURE_EN
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_data", {18'd0, rd_data}, 32'd42);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("arst_time", emu_time, 32'd0);
    check("arst_flag", {31'd0, time_flag}, 32'd0);
    check("arst_valid", {31'd0, rd_valid}, 32'd0);
    check("arst_data", {18'd0, rd_data}, 32'd0);
    check("arst_empty", {31'd0, cap_empty}, 32'd1);
    check("arst_full", {31'd0, cap_full}, 32'd0);
    check("arst_ovf", {31'd0, cap_ovf}, 32'd0);
    tick();
    rst = 1'b0;
    arm = 1'b0;
    emu_step = 1'b0;
    tick();
    check("post_rst_time", emu_time, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
